ps2_keycode_source: RTL and testbench

- Receives PS/2 keyboard frames and produces the 8-bit held-key `keycode` that the Tetris game logic consumes.
- This block is the producer end of the keycode interface: `keycode` is non-zero while a key is held and returns to 0 when that key is released.
- Sits between the board's PS/2 pins and the game top level, in the 50 MHz `Clk` domain.
- Also outputs one-cycle event pulses so the FSM can act on edges instead of on levels.

---
 rtl/ps2_keycode_source.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_keycode_source.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_source.sv
// ps2_keycode_source
//   Decodes PS/2 keyboard frames into the held-key level consumed by the game
//   logic, plus one-cycle edge pulses for make / release / framing errors.
//
// Ports
//   Clk          50 MHz system clock
//   Reset        synchronous, active-high
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   keycode      held make code, 0 when no key is held
//   ext          current keycode arrived with an E0 prefix
//   key_event    pulse: keycode took a new make code
//   key_release  pulse: keycode cleared by a matching break
//   frame_err    pulse: start, parity, stop or timeout error
//
// Pipeline: 2-FF sync -> edge detect -> frame FSM -> event register ->
// byte handling / output register. Output change lands 4 Clk after the raw
// ps2_clk falling edge of the stop bit.
module ps2_keycode_source #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       ext,
  output logic       key_event,
  output logic       key_release,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers and falling-edge detect. Idle-high bus, so the
  // flops reset to 1 to avoid a spurious fall after reset.
  // ---------------------------------------------------------------------
  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       r_clk_prev;
  logic       w_fall;
  logic       w_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_data = r_dat_sync[1];

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t        r_state, w_state_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic [2:0]    r_bitcnt, w_bitcnt_nx;
  logic          r_par, w_par_nx;
  logic [TW-1:0] r_tcnt, w_tcnt_nx;
  logic          w_good;       // stop-bit fall closed a valid frame
  logic          w_bad;        // parity/stop error or timeout
  logic          w_start_err;  // fall with data high while idle

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_shift  <= w_shift_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_par    <= w_par_nx;
      r_tcnt   <= w_tcnt_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_shift_nx  = r_shift;
    w_bitcnt_nx = r_bitcnt;
    w_par_nx    = r_par;
    w_tcnt_nx   = '0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_start_err = 1'b0;

    if (r_state == S_IDLE) begin
      if (w_fall) begin
        if (!w_data) begin
          w_state_nx  = S_DATA;
          w_bitcnt_nx = '0;
        end else begin
          w_start_err = 1'b1;
        end
      end
    end else if (w_fall) begin
      // Any fall inside a frame restarts the inactivity window.
      if (r_state == S_DATA) begin
        w_shift_nx = {w_data, r_shift[7:1]};   // LSB first
        if (r_bitcnt == 3'd7) w_state_nx = S_PARITY;
        else                  w_bitcnt_nx = r_bitcnt + 3'd1;
      end else if (r_state == S_PARITY) begin
        w_par_nx   = w_data;
        w_state_nx = S_STOP;
      end else begin
        // Odd parity over data+parity means the XOR of all nine bits is 1.
        if (w_data && (^{r_shift, r_par})) w_good = 1'b1;
        else                               w_bad  = 1'b1;
        w_state_nx = S_IDLE;
      end
    end else if (r_tcnt == TMAX) begin
      // Counter would reach TIMEOUT_CYCLES this cycle: abort the frame.
      w_bad      = 1'b1;
      w_state_nx = S_IDLE;
    end else begin
      w_tcnt_nx = r_tcnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Event register: one cycle between frame completion and byte handling.
  // At most one of these is set per cycle since only one fall or timeout
  // can happen per cycle.
  // ---------------------------------------------------------------------
  logic       r_ev_good;
  logic       r_ev_bad;
  logic       r_ev_serr;
  logic [7:0] r_ev_byte;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ev_good <= 1'b0;
      r_ev_bad  <= 1'b0;
      r_ev_serr <= 1'b0;
      r_ev_byte <= '0;
    end else begin
      r_ev_good <= w_good;
      r_ev_bad  <= w_bad;
      r_ev_serr <= w_start_err;
      if (w_good) r_ev_byte <= r_shift;
    end
  end

  // ---------------------------------------------------------------------
  // Byte handling: prefix tracking, make / break, output pulses.
  // ---------------------------------------------------------------------
  logic r_pend_e0;
  logic r_pend_f0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      keycode     <= '0;
      ext         <= 1'b0;
      key_event   <= 1'b0;
      key_release <= 1'b0;
      frame_err   <= 1'b0;
      r_pend_e0   <= 1'b0;
      r_pend_f0   <= 1'b0;
    end else begin
      key_event   <= 1'b0;
      key_release <= 1'b0;
      frame_err   <= 1'b0;

      if (r_ev_serr) begin
        // Stray fall while idle: report but leave prefixes alone.
        frame_err <= 1'b1;
      end else if (r_ev_bad) begin
        frame_err <= 1'b1;
        r_pend_e0 <= 1'b0;
        r_pend_f0 <= 1'b0;
      end else if (r_ev_good) begin
        if (r_ev_byte == 8'hE0) begin
          r_pend_e0 <= 1'b1;
        end else if (r_ev_byte == 8'hF0) begin
          r_pend_f0 <= 1'b1;
        end else if (r_pend_f0) begin
          // Break only clears a key if both code and E0 scope match.
          if (r_ev_byte == keycode && r_pend_e0 == ext) begin
            keycode     <= '0;
            ext         <= 1'b0;
            key_release <= 1'b1;
          end
          r_pend_e0 <= 1'b0;
          r_pend_f0 <= 1'b0;
        end else begin
          // Typematic repeats of the held key produce no pulse.
          if ({r_pend_e0, r_ev_byte} != {ext, keycode}) key_event <= 1'b1;
          keycode   <= r_ev_byte;
          ext       <= r_pend_e0;
          r_pend_e0 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_source.sv
module tb_ps2_keycode_source;
  localparam int TO = 50000;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       ext, key_event, key_release, frame_err;

  ps2_keycode_source #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .ext(ext), .key_event(key_event),
    .key_release(key_release), .frame_err(frame_err)
  );

  always #10 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // kind: 0 key_event, 1 key_release, 2 frame_err; lo/hi = allowed cycle window
  typedef struct {
    int         kind;
    logic [7:0] key;
    logic       ext;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model of the decoder state
  logic [7:0] mk = 8'h00;
  logic       mx = 1'b0, pe0 = 1'b0, pf0 = 1'b0;

  function automatic exp_t mk_exp(int kind, logic [7:0] k, logic x, int lo, int hi);
    exp_t e;
    e.kind = kind; e.key = k; e.ext = x; e.lo = lo; e.hi = hi;
    return e;
  endfunction

  // Scoreboard monitor: every pulse must match the head of the queue.
  initial begin
    exp_t e;
    int   k, npulse;
    forever begin
      @(posedge Clk); #1;
      npulse = int'(key_event) + int'(key_release) + int'(frame_err);
      if (npulse != 0) begin
        k = key_event ? 0 : (key_release ? 1 : 2);
        n_chk++;
        if (npulse != 1) begin
          n_fail++;
          $display("FAIL pulse_exclusive: cyc=%0d ev=%b rel=%b err=%b, required exactly one",
                   cyc, key_event, key_release, frame_err);
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: cyc=%0d kind=%0d key=%h ext=%b, required none",
                   cyc, k, keycode, ext);
        end else begin
          e = sb.pop_front();
          if (k !== e.kind || keycode !== e.key || ext !== e.ext || cyc < e.lo || cyc > e.hi) begin
            n_fail++;
            $display("FAIL pulse_match: got kind=%0d key=%h ext=%b cyc=%0d, required kind=%0d key=%h ext=%b cyc=%0d..%0d",
                     k, keycode, ext, cyc, e.kind, e.key, e.ext, e.lo, e.hi);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic ps2_fall(input logic v, output int st);
    wait_cyc(1);
    ps2_data = v;
    wait_cyc(10);
    ps2_clk = 1'b0;
    st = cyc;
  endtask

  task automatic ps2_rise();
    wait_cyc(10);
    ps2_clk = 1'b1;
  endtask

  // Predict outputs for one completed frame whose stop fall was at cycle st.
  task automatic model_frame(input logic [7:0] b, input logic good, input int st);
    if (!good) begin
      sb.push_back(mk_exp(2, mk, mx, st + 4, st + 4));
      pe0 = 1'b0; pf0 = 1'b0;
    end else if (b == 8'hE0) begin
      pe0 = 1'b1;
    end else if (b == 8'hF0) begin
      pf0 = 1'b1;
    end else if (pf0) begin
      if (b == mk && pe0 == mx) begin
        sb.push_back(mk_exp(1, 8'h00, 1'b0, st + 4, st + 4));
        mk = 8'h00; mx = 1'b0;
      end
      pe0 = 1'b0; pf0 = 1'b0;
    end else begin
      if ({pe0, b} != {mx, mk}) sb.push_back(mk_exp(0, b, pe0, st + 4, st + 4));
      mk = b; mx = pe0; pe0 = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    logic [10:0] bits;
    int st;
    bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};  // stop, parity, data, start
    for (int i = 0; i < 11; i++) begin
      ps2_fall(bits[i], st);
      if (i == 10) model_frame(b, !flip_par, st);
      ps2_rise();
    end
    wait_cyc(20);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    wait_cyc(3);
    Reset = 1'b0;
    wait_cyc(1);
    n_chk++;
    if ({keycode, ext, key_event, key_release, frame_err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: key=%h ext=%b ev=%b rel=%b err=%b, required all 0",
               keycode, ext, key_event, key_release, frame_err);
    end
  endtask

  task automatic test_make();
    send_frame(8'h1D, 1'b0);
    n_chk++;
    if (keycode !== 8'h1D || ext !== 1'b0) begin
      n_fail++;
      $display("FAIL make_1D: key=%h ext=%b, required 1d/0", keycode, ext);
    end
  endtask

  task automatic test_break_repeat();
    send_frame(8'h1D, 1'b0);
    n_chk++;
    if (keycode !== 8'h1D) begin
      n_fail++;
      $display("FAIL repeat_1D: key=%h, required 1d", keycode);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    n_chk++;
    if (keycode !== 8'h00 || ext !== 1'b0) begin
      n_fail++;
      $display("FAIL break_1D: key=%h ext=%b, required 00/0", keycode, ext);
    end
  endtask

  task automatic test_extended();
    send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    n_chk++;
    if (keycode !== 8'h75 || ext !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_make: key=%h ext=%b, required 75/1", keycode, ext);
    end
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h75, 1'b0);
    n_chk++;
    if (keycode !== 8'h00 || ext !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_break: key=%h ext=%b, required 00/0", keycode, ext);
    end
    send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    send_frame(8'hF0, 1'b0); send_frame(8'h75, 1'b0);
    n_chk++;
    if (keycode !== 8'h75 || ext !== 1'b1) begin
      n_fail++;
      $display("FAIL nonext_break: key=%h ext=%b, required 75/1", keycode, ext);
    end
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h75, 1'b0);
    n_chk++;
    if (keycode !== 8'h00) begin
      n_fail++;
      $display("FAIL ext_cleanup: key=%h, required 00", keycode);
    end
  endtask

  task automatic test_parity_err();
    send_frame(8'h1D, 1'b0);
    send_frame(8'h1C, 1'b1);
    n_chk++;
    if (keycode !== 8'h1D || ext !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_hold: key=%h ext=%b, required 1d/0", keycode, ext);
    end
    send_frame(8'h1C, 1'b0);
    n_chk++;
    if (keycode !== 8'h1C) begin
      n_fail++;
      $display("FAIL parity_recover: key=%h, required 1c", keycode);
    end
  endtask

  task automatic test_start_err();
    int st;
    ps2_fall(1'b1, st);
    sb.push_back(mk_exp(2, mk, mx, st + 4, st + 4));
    ps2_rise();
    wait_cyc(20);
    n_chk++;
    if (keycode !== 8'h1C) begin
      n_fail++;
      $display("FAIL start_err_hold: key=%h, required 1c", keycode);
    end
    send_frame(8'h1D, 1'b0);
    n_chk++;
    if (keycode !== 8'h1D) begin
      n_fail++;
      $display("FAIL start_err_recover: key=%h, required 1d", keycode);
    end
  endtask

  task automatic test_timeout();
    int st;
    logic [4:0] bits;
    send_frame(8'hF0, 1'b0); send_frame(8'h1D, 1'b0);
    bits = 5'b10110;  // start 0, then four data bits
    for (int i = 0; i < 5; i++) begin
      ps2_fall(bits[i], st);
      ps2_rise();
    end
    sb.push_back(mk_exp(2, 8'h00, 1'b0, st + TO, st + TO + 8));
    pe0 = 1'b0; pf0 = 1'b0;
    wait_cyc(TO + 40);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_err: %0d expected pulses outstanding, required 0", sb.size());
      sb.delete();
    end
    send_frame(8'h1C, 1'b0);
    n_chk++;
    if (keycode !== 8'h1C) begin
      n_fail++;
      $display("FAIL timeout_recover: key=%h, required 1c", keycode);
    end
  endtask

  task automatic test_reset_midframe();
    int st;
    logic [3:0] bits;
    bits = 4'b1010;  // start 0, then three data bits
    for (int i = 0; i < 4; i++) begin
      ps2_fall(bits[i], st);
      ps2_rise();
    end
    wait_cyc(1);
    Reset = 1'b1;
    wait_cyc(1);
    n_chk++;
    if (keycode !== 8'h00 || ext !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: key=%h ext=%b, required 00/0", keycode, ext);
    end
    Reset = 1'b0;
    mk = 8'h00; mx = 1'b0; pe0 = 1'b0; pf0 = 1'b0;
    wait_cyc(5);
    send_frame(8'h2A, 1'b0);
    n_chk++;
    if (keycode !== 8'h2A) begin
      n_fail++;
      $display("FAIL reset_recover: key=%h, required 2a", keycode);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break_repeat();
    test_extended();
    test_parity_err();
    test_start_err();
    test_timeout();
    test_reset_midframe();
    wait_cyc(20);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected pulses outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
